// File: rtl/mem_loader.sv
// Unified 256x15 program/data memory with a byte-serial host loader.
// Holds the processor in reset until the host issues the run command.
module mem_loader #(
  parameter int         DEPTH    = 256,
  parameter logic [7:0] CMD_LOAD = 8'hA5,
  parameter logic [7:0] CMD_RUN  = 8'h5A
) (
  input  logic       ph1,
  input  logic       ph2,
  input  logic       reset,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  output logic       ld_ready,
  output logic       ld_err,
  output logic       cpu_reset,
  output logic       running,
  input  logic [7:0] Adr,
  input  logic       MemWrite,
  output logic [6:0] MemData1,
  inout  wire  [7:0] MemData2
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_COUNT,
    S_HI,
    S_LO,
    S_RUN
  } state_t;

  logic [14:0] mem [DEPTH];

  state_t      state_q, state_m, state_d;
  logic [7:0]  waddr_q, waddr_m, waddr_d;
  logic [7:0]  wcnt_q, wcnt_m, wcnt_d;
  logic [6:0]  hi_q, hi_m, hi_d;
  logic        err_q, err_m, err_d;

  logic        xfer;
  logic        ld_wr;
  logic        st_wr;

  assign running   = (state_q == S_RUN);
  assign cpu_reset = ~running;
  assign ld_ready  = ~running;
  assign ld_err    = err_q;
  assign xfer      = ld_valid & ld_ready;
  assign st_wr     = running & MemWrite & ~reset;

  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    wcnt_d  = wcnt_q;
    hi_d    = hi_q;
    err_d   = err_q;
    ld_wr   = 1'b0;
    if (xfer) begin
      unique case (state_q)
        S_IDLE: begin
          if (ld_data == CMD_LOAD) begin
            state_d = S_ADDR;
            err_d   = 1'b0;
          end else if (ld_data == CMD_RUN) begin
            state_d = S_RUN;
          end else begin
            err_d   = 1'b1;
          end
        end
        S_ADDR: begin
          waddr_d = ld_data;
          state_d = S_COUNT;
        end
        S_COUNT: begin
          wcnt_d  = ld_data;
          state_d = S_HI;
        end
        S_HI: begin
          hi_d    = ld_data[6:0];
          state_d = S_LO;
        end
        S_LO: begin
          ld_wr   = ~reset;
          waddr_d = waddr_q + 8'd1;
          wcnt_d  = wcnt_q - 8'd1;
          // count 0 decrements through FF, so 256 words end at 1
          state_d = (wcnt_q == 8'd1) ? S_IDLE : S_HI;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge ph2) begin
    if (reset) begin
      state_m <= S_IDLE;
      waddr_m <= 8'd0;
      wcnt_m  <= 8'd0;
      hi_m    <= 7'd0;
      err_m   <= 1'b0;
    end else begin
      state_m <= state_d;
      waddr_m <= waddr_d;
      wcnt_m  <= wcnt_d;
      hi_m    <= hi_d;
      err_m   <= err_d;
    end
  end

  // Sampled on ph2, made visible on the following ph1.
  always_ff @(posedge ph1) begin
    state_q <= state_m;
    waddr_q <= waddr_m;
    wcnt_q  <= wcnt_m;
    hi_q    <= hi_m;
    err_q   <= err_m;
  end

  always_ff @(posedge ph2) begin
    if (ld_wr)
      mem[waddr_q] <= {hi_q, ld_data};
    else if (st_wr)
      mem[Adr][7:0] <= MemData2;
  end

  assign MemData1 = running ? mem[Adr][14:8] : 7'd0;
  assign MemData2 = (running & ~MemWrite) ? mem[Adr][7:0] : 'z;

endmodule
